// File: rtl/bram_tdp_pipelined_pkg.sv
// Shared types, constants and helpers for the pipelined true dual-port BRAM.
package bram_pkg;

    typedef enum logic {RDW_OLD = 1'b0, RDW_NEW = 1'b1} rdw_mode_e;
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} fsm_state_e;

    localparam int COLL_CNT_W = 16;

    function automatic int nb(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/bram_tdp_pipelined_rd_pipe.sv
// Read-data output pipeline: one registered stage plus READ_LATENCY-1 extra stages.
module bram_tdp_rd_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    logic                  s0_valid;
    logic [DATA_WIDTH-1:0] s0_data;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else begin
            s0_valid <= req;
            if (req) begin
                s0_data <= req_data;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_extra
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= s0_valid;
                if (s0_valid) begin
                    s1_data <= s0_data;
                end
            end
        end

        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
    end else begin : g_direct
        assign rd_valid = s0_valid;
        assign rd_data  = s0_data;
    end

endmodule

// File: rtl/bram_tdp_pipelined.sv
// True dual-port byte-enabled RAM with zero-init sweep, selectable read latency and collision detection.
module bram_tdp_pipelined
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int INIT_ZERO    = 1
) (
    input  logic                                CLK,
    input  logic                                RST_N,
    input  logic                                EN_A,
    input  logic                                EN_B,
    input  logic                                WE_A,
    input  logic                                WE_B,
    input  logic [nb(DATA_WIDTH,BYTE_WIDTH)-1:0] BE_A,
    input  logic [nb(DATA_WIDTH,BYTE_WIDTH)-1:0] BE_B,
    input  logic [ADDR_WIDTH-1:0]               ADDR_A,
    input  logic [ADDR_WIDTH-1:0]               ADDR_B,
    input  logic [DATA_WIDTH-1:0]               DI_A,
    input  logic [DATA_WIDTH-1:0]               DI_B,
    output logic [DATA_WIDTH-1:0]               DO_A,
    output logic [DATA_WIDTH-1:0]               DO_B,
    output logic                                DO_VALID_A,
    output logic                                DO_VALID_B,
    output logic                                READY,
    output logic                                COLLISION,
    output logic [COLL_CNT_W-1:0]               COLL_COUNT
);

    localparam int        NB    = nb(DATA_WIDTH, BYTE_WIDTH);
    localparam int        DEPTH = 1 << ADDR_WIDTH;
    localparam rdw_mode_e RDW   = (RDW_MODE != 0) ? RDW_NEW : RDW_OLD;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_bw
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_chk_rl
        $error("READ_LATENCY must be 1 or 2");
    end

    (* ramstyle = "m20k" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    fsm_state_e             state;
    logic [ADDR_WIDTH-1:0]  init_ctr;
    logic                   ready_q;
    logic                   coll_q;
    logic [COLL_CNT_W-1:0]  coll_cnt;

    logic acc_a, acc_b, coll_now, drop_b, wr_a, wr_b, req_a, req_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, new_b_eff;
    logic [DATA_WIDTH-1:0] req_data_a, req_data_b;

    assign acc_a    = ready_q & EN_A;
    assign acc_b    = ready_q & EN_B;
    assign coll_now = acc_a & acc_b & (ADDR_A == ADDR_B) & (WE_A | WE_B);
    assign drop_b   = coll_now & WE_A & WE_B;
    assign wr_a     = acc_a & WE_A;
    assign wr_b     = acc_b & WE_B & ~drop_b;

    always_comb begin
        old_a = mem[ADDR_A];
        old_b = mem[ADDR_B];
        new_a = old_a;
        new_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (BE_A[i]) new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = DI_A[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (BE_B[i]) new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = DI_B[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // A dropped B write leaves the word as A's merge, so B's read-back sees that word
    assign new_b_eff  = drop_b ? new_a : new_b;
    assign req_a      = acc_a & (~WE_A | (RDW == RDW_NEW));
    assign req_b      = acc_b & (~WE_B | (RDW == RDW_NEW));
    assign req_data_a = WE_A ? new_a : old_a;
    assign req_data_b = WE_B ? new_b_eff : old_b;

    always_ff @(posedge CLK) begin
        if (state == ST_INIT) begin
            mem[init_ctr] <= '0;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_a && BE_A[i])
                    mem[ADDR_A][i*BYTE_WIDTH +: BYTE_WIDTH] <= DI_A[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr_b && BE_B[i])
                    mem[ADDR_B][i*BYTE_WIDTH +: BYTE_WIDTH] <= DI_B[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            if (INIT_ZERO != 0) state <= ST_INIT;
            else                state <= ST_RUN;
            init_ctr <= '0;
            ready_q  <= 1'b0;
            coll_q   <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll_q <= coll_now;
            if (coll_now && coll_cnt != '1) begin
                coll_cnt <= coll_cnt + COLL_CNT_W'(1);
            end
            case (state)
                ST_INIT: begin
                    init_ctr <= init_ctr + ADDR_WIDTH'(1);
                    if (init_ctr == '1) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign READY      = ready_q;
    assign COLLISION  = coll_q;
    assign COLL_COUNT = coll_cnt;

    bram_tdp_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
        .CLK(CLK), .RST_N(RST_N), .req(req_a), .req_data(req_data_a),
        .rd_data(DO_A), .rd_valid(DO_VALID_A)
    );

    bram_tdp_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
        .CLK(CLK), .RST_N(RST_N), .req(req_b), .req_data(req_data_b),
        .rd_data(DO_B), .rd_valid(DO_VALID_B)
    );

endmodule
